// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage controller and the ALU.
// The controller drives the operands; the ALU returns the result and flags.
interface alu_if;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [1:0]  ALUop;
  logic        loads;
  logic [15:0] out;
  logic        Z;
  logic [3:0]  status;

  modport master (
    output Ain, Bin, ALUop, loads,
    input  out, Z, status
  );

  modport slave (
    input  Ain, Bin, ALUop, loads,
    output out, Z, status
  );
endinterface

// File: rtl/alu.sv
// 16-bit add/sub/and/not-b ALU with a combinational zero flag and a
// clocked {Z,N,V,C} status register loaded on demand.
module alu (
  input logic  clk,
  input logic  reset,
  alu_if.slave bus
);

  logic [15:0] b_eff;
  logic [16:0] sum;
  logic [15:0] res;
  logic        is_arith;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic        flag_c;

  // Subtract shares the adder: Ain + ~Bin + 1, so sum[16] is the no-borrow bit.
  always_comb begin
    b_eff = bus.ALUop[0] ? ~bus.Bin : bus.Bin;
    sum   = {1'b0, bus.Ain} + {1'b0, b_eff} + {16'h0000, bus.ALUop[0]};
  end

  always_comb begin
    res      = 'x;
    is_arith = 1'b0;
    case (bus.ALUop)
      2'b00: begin
        res      = sum[15:0];
        is_arith = 1'b1;
      end
      2'b01: begin
        res      = sum[15:0];
        is_arith = 1'b1;
      end
      2'b10:   res = bus.Ain & bus.Bin;
      2'b11:   res = ~bus.Bin;
      default: res = 'x;
    endcase
  end

  always_comb begin
    flag_z = (res == 16'h0000);
    flag_n = res[15];
    flag_v = is_arith & (bus.Ain[15] == b_eff[15]) & (res[15] != bus.Ain[15]);
    flag_c = is_arith & sum[16];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.status <= 4'b0000;
    end else if (bus.loads) begin
      bus.status <= {flag_z, flag_n, flag_v, flag_c};
    end
  end

  assign bus.out = res;
  assign bus.Z   = flag_z;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: the driver queues hand-computed expectations,
// a monitor on the falling edge pops and compares against the DUT.
module tb_alu;

  logic clk;
  logic reset;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] out;
    logic        z;
    logic [3:0]  st;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_no   = 0;

  task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ld, input logic rst,
                       input logic [15:0] e_out, input logic e_z, input logic [3:0] e_st);
    exp_t e;
    @(posedge clk);
    #1;
    bus.ALUop = op;
    bus.Ain   = a;
    bus.Bin   = b;
    bus.loads = ld;
    reset     = rst;
    e.idx = vec_no;
    e.out = e_out;
    e.z   = e_z;
    e.st  = e_st;
    q.push_back(e);
    vec_no++;
  endtask

  // Monitor: result and flags are settled by the falling edge of each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.out !== e.out) begin
          failures++;
          $display("FAIL out[%0d]: got %h expected %h", e.idx, bus.out, e.out);
        end
        checks++;
        if (bus.Z !== e.z) begin
          failures++;
          $display("FAIL z[%0d]: got %b expected %b", e.idx, bus.Z, e.z);
        end
        checks++;
        if (bus.status !== e.st) begin
          failures++;
          $display("FAIL status[%0d]: got %b expected %b", e.idx, bus.status, e.st);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    reset     = 1'b1;
    bus.ALUop = 2'b00;
    bus.Ain   = 16'h0000;
    bus.Bin   = 16'h0000;
    bus.loads = 1'b0;
    repeat (2) @(posedge clk);

    // status column is what must be visible during that row (loads act at the row's closing edge)
    //     op     Ain       Bin       ld    rst   out       Z     status
    drive(2'b00, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 4'b0000);
    drive(2'b01, 16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 4'b0000);
    drive(2'b01, 16'h0001, 16'h0003, 1'b1, 1'b0, 16'hFFFE, 1'b0, 4'b0000);
    drive(2'b10, 16'h4403, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0100);
    drive(2'b11, 16'h0003, 16'hFFFE, 1'b0, 1'b0, 16'h0001, 1'b0, 4'b0100);
    drive(2'b00, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 4'b0100);
    drive(2'b00, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b0110);
    drive(2'b00, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 4'b1001);
    drive(2'b10, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF000, 1'b0, 4'b1001);
    drive(2'b11, 16'h5555, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 4'b1001);
    drive(2'b01, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b0, 4'b1001);
    drive(2'b01, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 4'b0000);
    drive(2'b01, 16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b0011);
    drive(2'b10, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 4'b1001);
    drive(2'b00, 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b1001);
    drive(2'b11, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b1011);
    drive(2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1000);

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
